sample_buffer: RTL and testbench

Elastic FIFO stage directly downstream of the sampler. Absorbs the sampler's strobe-only compressed word stream (`out_data`/`out_valid`, no backpressure) and presents it to the host transport through a valid/ready handshake. Reports fill level and a sticky overflow flag. Accepts flush and clear commands on the shared control write bus.

---
 rtl/sample_buffer_pkg.sv | 12 +
 rtl/sample_buffer_ram.sv | 23 ++
 rtl/sample_buffer.sv | 133 +++++++++++++
 tb/tb_sample_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_buffer_pkg.sv
// Shared constants for the sample buffer and its control-space decoder.
package sample_buffer_pkg;

  localparam int SB_WORD_W = 16;

  localparam logic [3:0] SB_REG_CTRL = 4'h0;
  localparam int SB_CTRL_FLUSH   = 0;
  localparam int SB_CTRL_CLR_OVF = 1;

  typedef logic [SB_WORD_W-1:0] sb_word_t;

endpackage

// File: rtl/sample_buffer_ram.sv
// Single-clock dual-port RAM, one write and one registered read per cycle.
module sample_buffer_ram
  import sample_buffer_pkg::*;
#(
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  sb_word_t      wdata,
  input  logic [aw-1:0] raddr,
  input  logic          re,
  output sb_word_t      rdata
);

  sb_word_t mem [2**aw];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_buffer.sv
// Elastic FIFO between the sampler strobe stream and the host valid/ready port.
// RAM read result lands in a registered output stage backed by a one-entry skid.
module sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   in_data,
  input  logic          in_strobe,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [aw:0]   level,
  output logic          overflow,
  input  logic [3:0]    waddr,
  input  logic [31:0]   wdata,
  input  logic          wvalid
);

  localparam int lw = aw + 1;
  localparam logic [aw:0] depth = {1'b1, {aw{1'b0}}};

  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [aw:0]   ram_cnt;
  logic          rd_pend, byp_sel;
  sb_word_t      byp_data, rdata, head_d;
  logic          skid_valid;
  sb_word_t      skid_data;

  logic ctrl_hit, flush, clr_ovf;
  logic wr_acc, drop, cons, room, rd_ram, rd_byp, issue;
  logic [1:0] occ;

  logic     out_valid_n, skid_valid_n;
  sb_word_t out_data_n, skid_data_n;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:2];

  assign ctrl_hit = wvalid && (waddr == SB_REG_CTRL);
  assign flush    = ctrl_hit && wdata[SB_CTRL_FLUSH];
  assign clr_ovf  = ctrl_hit && wdata[SB_CTRL_CLR_OVF];

  assign wr_acc = in_strobe && (level != depth) && !flush;
  assign drop   = in_strobe && (level == depth);
  assign cons   = out_valid && out_ready;

  // Words already committed downstream: output reg, skid, and the read in flight.
  assign occ    = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
  assign room   = (occ - {1'b0, cons}) < 2'd2;
  assign rd_ram = room && (ram_cnt != '0);
  // Empty RAM: forward the incoming word through a register that mimics the read latency.
  assign rd_byp = room && (ram_cnt == '0) && wr_acc;
  assign issue  = rd_ram || rd_byp;
  assign head_d = byp_sel ? byp_data : rdata;

  sample_buffer_ram #(.aw(aw)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .re    (rd_ram),
    .rdata (rdata)
  );

  always_comb begin
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (!out_valid || cons) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_data_n   = skid_data;
        skid_valid_n = rd_pend;
        if (rd_pend) skid_data_n = head_d;
      end else begin
        out_valid_n = rd_pend;
        if (rd_pend) out_data_n = head_d;
      end
    end else if (rd_pend) begin
      skid_valid_n = 1'b1;
      skid_data_n  = head_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      level      <= '0;
      rd_pend    <= 1'b0;
      byp_sel    <= 1'b0;
      byp_data   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        ram_cnt    <= '0;
        level      <= '0;
        rd_pend    <= 1'b0;
        byp_sel    <= 1'b0;
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (issue)  rd_ptr <= rd_ptr + 1'b1;
        ram_cnt    <= ram_cnt + lw'(wr_acc) - lw'(issue);
        level      <= level + lw'(wr_acc) - lw'(cons);
        rd_pend    <= issue;
        byp_sel    <= rd_byp;
        if (rd_byp) byp_data <= in_data;
        out_valid  <= out_valid_n;
        out_data   <= out_data_n;
        skid_valid <= skid_valid_n;
        skid_data  <= skid_data_n;
      end
    end
  end

endmodule

// File: tb/tb_sample_buffer.sv
// Scoreboard bench for sample_buffer with a 16-word buffer.
module tb_sample_buffer;

  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   in_data = '0;
  logic          in_strobe = 1'b0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   level;
  logic          overflow;
  logic [3:0]    waddr = '0;
  logic [31:0]   wdata = '0;
  logic          wvalid = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic flush_cyc = 1'b0;

  sample_buffer #(.aw(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .waddr     (waddr),
    .wdata     (wdata),
    .wvalid    (wvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the scoreboard accepts the word only if the model has room.
  task automatic cyc(input logic s, input logic [15:0] d, input logic r,
                     input logic wv = 1'b0, input logic [3:0] wa = 4'h0,
                     input logic [31:0] wd = 32'h0);
    logic fl;
    fl = wv && (wa == 4'h0) && wd[0];
    in_strobe = s; in_data = d; out_ready = r;
    wvalid = wv; waddr = wa; wdata = wd; flush_cyc = fl;
    if (s && !fl && exp_q.size() < D) exp_q.push_back(d);
    @(posedge clk); #1;
    if (fl) exp_q.delete();
    flush_cyc = 1'b0; in_strobe = 1'b0; wvalid = 1'b0;
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b1);
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_level0"}, level, 0);
  endtask

  // Monitor: pops on every handshake and checks hold-while-stalled.
  initial begin
    logic prev_stall, prev_flush;
    logic [15:0] prev_data, e;
    prev_stall = 1'b0; prev_flush = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall && !prev_flush) begin
          checks++;
          if (!(out_valid && out_data == prev_data)) begin
            errors++;
            $display("FAIL stall_hold actual=%0b/%0h required=1/%0h", out_valid, out_data, prev_data);
          end
        end
        if (out_valid && out_ready && !flush_cyc) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word actual=%0h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              errors++;
              $display("FAIL out_word actual=%0h required=%0h", out_data, e);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_flush = flush_cyc;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int vcnt, gaps;
    logic seen, prev;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: latency
    cyc(1'b1, 16'h1234, 1'b1);
    chk("lat_n1_valid", out_valid, 0);
    chk("lat_n1_level", level, 1);
    cyc(1'b0, 16'h0, 1'b1);
    chk("lat_n2_valid", out_valid, 1);
    chk("lat_n2_data", out_data, 16'h1234);
    chk("lat_n2_level", level, 1);
    cyc(1'b0, 16'h0, 1'b1);
    chk("lat_n3_valid", out_valid, 0);
    chk("lat_n3_level", level, 0);

    // 2: burst
    vcnt = 0; gaps = 0; seen = 1'b0; prev = 1'b0;
    for (int i = 0; i < 19; i++) begin
      cyc(i < 16, 16'(i), 1'b1);
      if (out_valid) vcnt++;
      if (seen && !prev && out_valid) gaps++;
      if (out_valid) seen = 1'b1;
      prev = out_valid;
    end
    chk("burst_valid_cycles", vcnt, 16);
    chk("burst_gaps", gaps, 0);
    chk("burst_overflow", overflow, 0);
    drain("burst", 4);

    // 3: fill and drop
    for (int i = 0; i < 18; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0);
    chk("fill_level", level, 16);
    chk("fill_overflow", overflow, 1);
    drain("fill", 22);

    // 4: random backpressure
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'h0, 32'h2);
    for (int i = 0; i < 2000; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    drain("rand", 40);

    // 5: simultaneous drop and handshake at full, then wrap
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'h0, 32'h2);
    chk("wrap_ovf_cleared", overflow, 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    chk("wrap_full_level", level, 16);
    cyc(1'b1, 16'h5555, 1'b1);
    chk("simul_level", level, 15);
    chk("simul_overflow", overflow, 1);
    for (int i = 0; i < 40; i++) cyc(1'b1, 16'h5000 + 16'(i), 1'b1);
    drain("wrap", 25);

    // 6: flush + clear with a concurrent strobe
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h6000 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    chk("ctrl_pre_level", level, 5);
    chk("ctrl_pre_ovf", overflow, 1);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b1, 4'h0, 32'h3);
    chk("flush_level", level, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1);
    chk("flush_after_valid", out_valid, 0);
    chk("flush_after_level", level, 0);

    for (int i = 0; i < 17; i++) cyc(1'b1, 16'h7000 + 16'(i), 1'b0);
    chk("clr_pre_ovf", overflow, 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'h0, 32'h2);
    chk("clr_only_ovf", overflow, 0);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 4'h0, 32'h2);
    chk("clr_vs_drop_ovf", overflow, 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'h1, 32'h3);
    chk("other_addr_level", level, 16);
    chk("other_addr_ovf", overflow, 1);
    drain("ctrl", 22);

    // async reset mid-stream
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'h8000 + 16'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ovf", overflow, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h9000 + 16'(i), 1'b1);
    drain("post_rst", 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
